// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int steps_f(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter must be at least one bit wide even for a single-step configuration.
    function automatic int cnt_width_f(input int steps);
        if (steps <= 1) begin
            return 1;
        end else begin
            return $clog2(steps);
        end
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle between a requester and the serial subtractor.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor_fs_slice.sv
// Combinational DIGIT-bit ripple of 1-bit full subtractors: d = a - b - bin.
module fs_slice
    import serial_subtractor_pkg::*;
#(
    parameter int DIGIT = 1
)(
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             bin_i,
    output logic [DIGIT-1:0] d_o,
    output logic             bout_o
);

    logic [DIGIT:0] borrow_s;

    assign borrow_s[0] = bin_i;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_cell
            assign d_o[gi]         = a_i[gi] ^ b_i[gi] ^ borrow_s[gi];
            assign borrow_s[gi+1]  = (~a_i[gi] & b_i[gi]) | (~a_i[gi] & borrow_s[gi]) | (b_i[gi] & borrow_s[gi]);
        end
    endgenerate

    assign bout_o = borrow_s[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: DIGIT bits per clock, borrow carried between cycles, start/busy/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $fatal(1, "serial_subtractor: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    localparam int             STEPS    = steps_f(WIDTH, DIGIT);
    localparam int             CW       = cnt_width_f(STEPS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STEPS - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] partial_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    logic [DIGIT-1:0]       slice_d_s;
    logic                   slice_bo_s;
    logic [WIDTH+DIGIT-1:0] partial_wide_s;
    logic [WIDTH-1:0]       partial_d;
    logic [WIDTH-1:0]       op_a_d;
    logic [WIDTH-1:0]       op_b_d;

    fs_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a_i    (op_a_q[DIGIT-1:0]),
        .b_i    (op_b_q[DIGIT-1:0]),
        .bin_i  (borrow_q),
        .d_o    (slice_d_s),
        .bout_o (slice_bo_s)
    );

    // New result digits enter at the MSB end so the finished word lands aligned after STEPS shifts.
    assign partial_wide_s = {slice_d_s, partial_q};
    assign partial_d      = partial_wide_s[WIDTH+DIGIT-1:DIGIT];
    assign op_a_d         = op_a_q >> DIGIT;
    assign op_b_d         = op_b_q >> DIGIT;

    // Control FSM and datapath registers, including the registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            partial_q <= '0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        op_a_q    <= bus.a;
                        op_b_q    <= bus.b;
                        borrow_q  <= bus.bin;
                        a_msb_q   <= bus.a[WIDTH-1];
                        b_msb_q   <= bus.b[WIDTH-1];
                        partial_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end else begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    op_a_q    <= op_a_d;
                    op_b_q    <= op_b_d;
                    partial_q <= partial_d;
                    borrow_q  <= slice_bo_s;
                    cnt_q     <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        diff_q  <= partial_d;
                        bout_q  <= slice_bo_s;
                        ovf_q   <= (a_msb_q != b_msb_q) && (partial_d[WIDTH-1] != a_msb_q);
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor in three configurations (W1/D1, W8/D1, W8/D4).
module tb_serial_subtractor;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(1)) if1 ();
    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(8)) if84 ();

    serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut84 (.clk(clk), .rst_n(rst_n), .bus(if84));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if1.start = 1'b0;  if1.a = 1'b0;   if1.b = 1'b0;   if1.bin = 1'b0;
        if8.start = 1'b0;  if8.a = 8'h00;  if8.b = 8'h00;  if8.bin = 1'b0;
        if84.start = 1'b0; if84.a = 8'h00; if84.b = 8'h00; if84.bin = 1'b0;
        tick();
        tick();
        checks++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.diff !== 1'b0 || if1.bout !== 1'b0 || if1.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_w1: busy=%b done=%b diff=%b bout=%b ovf=%b, expected all 0", if1.busy, if1.done, if1.diff, if1.bout, if1.ovf);
        end
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.diff !== 8'h00 || if8.bout !== 1'b0 || if8.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_w8: busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0", if8.busy, if8.done, if8.diff, if8.bout, if8.ovf);
        end
        checks++;
        if (if84.busy !== 1'b0 || if84.done !== 1'b0 || if84.diff !== 8'h00 || if84.bout !== 1'b0 || if84.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_w84: busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0", if84.busy, if84.done, if84.diff, if84.bout, if84.ovf);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Truth table of a - b - bin for index {a,b,bin}, hand-computed.
    task automatic test_w1_truth_table();
        logic [7:0] exp_d;
        logic [7:0] exp_bo;
        logic [2:0] idx;
        exp_d  = 8'b1001_0110;
        exp_bo = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            if1.a = idx[2]; if1.b = idx[1]; if1.bin = idx[0]; if1.start = 1'b1;
            tick();
            if1.start = 1'b0;
            checks++;
            if (if1.busy !== 1'b1 || if1.done !== 1'b0) begin
                errors++;
                $display("FAIL w1_cycle1_%0d: busy=%b done=%b, expected busy=1 done=0", i, if1.busy, if1.done);
            end
            tick();
            checks++;
            if (if1.done !== 1'b1 || if1.busy !== 1'b0 || if1.diff !== exp_d[i] || if1.bout !== exp_bo[i]) begin
                errors++;
                $display("FAIL w1_truth_%0d: done=%b busy=%b diff=%b bout=%b, expected done=1 busy=0 diff=%b bout=%b",
                         i, if1.done, if1.busy, if1.diff, if1.bout, exp_d[i], exp_bo[i]);
            end
            tick();
        end
    endtask

    task automatic test_w8_digit1();
        logic [7:0] va   [4];
        logic [7:0] vb   [4];
        logic       vbin [4];
        logic [7:0] ed   [4];
        logic       ebo  [4];
        logic       eov  [4];
        logic [7:0] prev_d;
        logic       prev_bo;
        logic       prev_ov;
        va[0] = 8'h05; vb[0] = 8'h03; vbin[0] = 1'b0; ed[0] = 8'h02; ebo[0] = 1'b0; eov[0] = 1'b0;
        va[1] = 8'h03; vb[1] = 8'h05; vbin[1] = 1'b0; ed[1] = 8'hFE; ebo[1] = 1'b1; eov[1] = 1'b0;
        va[2] = 8'h80; vb[2] = 8'h01; vbin[2] = 1'b0; ed[2] = 8'h7F; ebo[2] = 1'b0; eov[2] = 1'b1;
        va[3] = 8'h00; vb[3] = 8'h00; vbin[3] = 1'b1; ed[3] = 8'hFF; ebo[3] = 1'b1; eov[3] = 1'b0;
        prev_d = 8'h00; prev_bo = 1'b0; prev_ov = 1'b0;
        for (int v = 0; v < 4; v++) begin
            if8.a = va[v]; if8.b = vb[v]; if8.bin = vbin[v]; if8.start = 1'b1;
            for (int k = 1; k <= 9; k++) begin
                tick();
                if8.start = 1'b0;
                if8.a = 8'hFF; if8.b = 8'hFF; if8.bin = 1'b1;
                checks++;
                if (if8.busy !== (k <= 8) || if8.done !== (k == 9)) begin
                    errors++;
                    $display("FAIL w8_timing_v%0d_c%0d: busy=%b done=%b, expected busy=%b done=%b",
                             v, k, if8.busy, if8.done, (k <= 8), (k == 9));
                end
                if (k <= 8) begin
                    checks++;
                    if (if8.diff !== prev_d || if8.bout !== prev_bo || if8.ovf !== prev_ov) begin
                        errors++;
                        $display("FAIL w8_hold_v%0d_c%0d: diff=%h bout=%b ovf=%b, expected held %h %b %b",
                                 v, k, if8.diff, if8.bout, if8.ovf, prev_d, prev_bo, prev_ov);
                    end
                end else begin
                    checks++;
                    if (if8.diff !== ed[v] || if8.bout !== ebo[v] || if8.ovf !== eov[v]) begin
                        errors++;
                        $display("FAIL w8_result_v%0d: diff=%h bout=%b ovf=%b, expected %h %b %b",
                                 v, if8.diff, if8.bout, if8.ovf, ed[v], ebo[v], eov[v]);
                    end
                end
            end
            prev_d = ed[v]; prev_bo = ebo[v]; prev_ov = eov[v];
            tick();
            checks++;
            if (if8.done !== 1'b0 || if8.diff !== prev_d) begin
                errors++;
                $display("FAIL w8_after_done_v%0d: done=%b diff=%h, expected done=0 diff=%h", v, if8.done, if8.diff, prev_d);
            end
        end
    endtask

    // Start held high from cycle 0 through the first DONE cycle.
    task automatic test_back_to_back();
        logic       exp_busy;
        logic       exp_done;
        if84.a = 8'hA5; if84.b = 8'h5A; if84.bin = 1'b0; if84.start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                if84.a = 8'h10; if84.b = 8'h01;
            end
            if (k == 4) begin
                if84.start = 1'b0;
            end
            exp_busy = (k == 1 || k == 2 || k == 4 || k == 5);
            exp_done = (k == 3 || k == 6);
            checks++;
            if (if84.busy !== exp_busy || if84.done !== exp_done) begin
                errors++;
                $display("FAIL b2b_timing_c%0d: busy=%b done=%b, expected busy=%b done=%b", k, if84.busy, if84.done, exp_busy, exp_done);
            end
            if (k >= 3 && k <= 5) begin
                checks++;
                if (if84.diff !== 8'h4B || if84.bout !== 1'b0 || if84.ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_first_c%0d: diff=%h bout=%b ovf=%b, expected 4b 0 1", k, if84.diff, if84.bout, if84.ovf);
                end
            end
            if (k == 6) begin
                checks++;
                if (if84.diff !== 8'h0F || if84.bout !== 1'b0 || if84.ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second: diff=%h bout=%b ovf=%b, expected 0f 0 0", if84.diff, if84.bout, if84.ovf);
                end
            end
        end
        tick();
    endtask

    task automatic test_start_during_run();
        if8.a = 8'h80; if8.b = 8'h01; if8.bin = 1'b0; if8.start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k <= 7) begin
                if8.start = k[0];
                if8.a = 8'h00; if8.b = 8'hFF; if8.bin = 1'b1;
            end else begin
                if8.start = 1'b0;
            end
        end
        checks++;
        if (if8.done !== 1'b1 || if8.diff !== 8'h7F || if8.bout !== 1'b0 || if8.ovf !== 1'b1) begin
            errors++;
            $display("FAIL start_in_run: done=%b diff=%h bout=%b ovf=%b, expected 1 7f 0 1", if8.done, if8.diff, if8.bout, if8.ovf);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        if8.a = 8'h03; if8.b = 8'h05; if8.bin = 1'b0; if8.start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if8.start = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.diff !== 8'h00 || if8.bout !== 1'b0 || if8.ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0", if8.busy, if8.done, if8.diff, if8.bout, if8.ovf);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b done=%b, expected 0 0", if8.busy, if8.done);
        end
        if8.a = 8'h05; if8.b = 8'h03; if8.bin = 1'b0; if8.start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if8.start = 1'b0;
        end
        checks++;
        if (if8.done !== 1'b1 || if8.diff !== 8'h02 || if8.bout !== 1'b0 || if8.ovf !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_op: done=%b diff=%h bout=%b ovf=%b, expected 1 02 0 0", if8.done, if8.diff, if8.bout, if8.ovf);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_w1_truth_table();
        test_w8_digit1();
        test_back_to_back();
        test_start_during_run();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor that computes diff = a - b - bin over WIDTH bits. It processes DIGIT bits per clock through a ripple of 1-bit full-subtractor cells and carries the borrow between cycles in a register. Operands are accepted with a start/busy/done handshake. It replaces the single-bit combinational full subtractor wherever wide subtraction must fit a small area budget, and it also provides signed-overflow reporting.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
DIGIT, 1, bits processed per clock; must divide WIDTH exactly (elaboration-time check, fatal on violation)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; results valid
diff  output  WIDTH  difference, registered
bout  output  1  final borrow-out (unsigned a < b + bin)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. When rst_n is low at a clock edge, the block enters IDLE and clears busy, done, diff, bout, ovf and all internal shift, borrow and count registers to 0. This applies in any state, including mid-RUN; the partial operation is discarded.
- States: IDLE, RUN, DONE; STEPS = WIDTH/DIGIT.
- IDLE/DONE with start=1: latch a and b into the operand shift registers, load the borrow register from bin, save the MSBs of a and b, clear the step counter, go to RUN.
- IDLE with start=0: hold.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - the slice computes the low DIGIT bits of op_a - op_b - borrow;
  - the result bits shift into the partial register from the MSB end;
  - the operands shift right by DIGIT;
  - the borrow register takes the slice borrow-out;
  - the counter increments.
- Final RUN step (counter = STEPS-1):
  - diff is loaded with the completed partial value;
  - bout is loaded with the final borrow;
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb);
  - go to DONE.
- start during RUN is ignored; operands are not re-sampled.
- Latency: start high in cycle 0 gives busy high in cycles 1..STEPS and done high in cycle STEPS+1. Back-to-back: start in the DONE cycle re-enters RUN, so throughput is one result per STEPS+1 cycles.
- Outputs:
  - diff, bout and ovf change only on the final RUN step or on reset, and hold between operations.
  - busy = (state == RUN); done = (state == DONE).
- Width rules: internal arithmetic is modulo 2^WIDTH. A borrow-in of 1 is honoured in every mode.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing STEPS;
  - a function computing the counter width, clog2(STEPS) with a minimum of 1.
- One natural sub-module, fs_slice (combinational, DIGIT-bit ripple of 1-bit full subtractors). Per-bit equations: d = a^b^c; bo = (~a&b) | (~a&c) | (b&c).

Test Plan:
- WIDTH=1, DIGIT=1, all 8 (a,b,bin) combos -> diff/bout match the full-subtractor truth table: (0,0,1)->1/1, (1,0,0)->1/0, (0,1,1)->0/1, (1,1,1)->1/1; done in cycle 2 each time.
- WIDTH=8, DIGIT=1 cases:
  - 8'h05 - 8'h03, bin=0 -> diff 8'h02, bout 0, ovf 0; busy cycles 1-8, done pulse in cycle 9 only.
  - 8'h03 - 8'h05 -> diff 8'hFE, bout 1, ovf 0.
  - 8'h80 - 8'h01 -> diff 8'h7F, bout 0, ovf 1.
  - 8'h00 - 8'h00, bin=1 -> diff 8'hFF, bout 1, ovf 0.
- WIDTH=8, DIGIT=4: 8'hA5 - 8'h5A, then start held high through DONE with 8'h10 - 8'h01.
  - First result: done in cycle 3 with diff 8'h4B, bout 0, ovf 1.
  - Second operation: busy again in cycles 4-5; done in cycle 6 with diff 8'h0F.
- Mid-operation control, WIDTH=8, DIGIT=1:
  - Toggle start during RUN -> no effect on the result.
  - Drop rst_n in cycle 4 -> next cycle busy=0, done=0, diff=0, bout=0, ovf=0.
  - Then start 8'h05 - 8'h03 -> diff 8'h02 nine cycles later.
